// File: rtl/regfile_param_pkg.sv
// Shared constants and helpers for the parametrised register file.
package regfile_param_pkg;

    localparam int ZERO_IDX   = 0;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_AW     = 5;

    // Smallest r such that 2**r >= n; used to confirm AW can reach every register.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// NREGS:1 read selector; addresses with no backing register read as zero.
module regfile_read_mux
    import regfile_param_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW
) (
    input  logic [NREGS-1:0][WIDTH-1:0] regs,
    input  logic [AW-1:0]               addr,
    output logic [WIDTH-1:0]            data
);

    // Compare-and-select over the real registers only, so out-of-range stays 0.
    always_comb begin
        data = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (addr == AW'(r)) data = regs[r];
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: NRD read ports, one write port, optional
// zero register, write-to-read bypass and registered read stage.
module regfile_param
    import regfile_param_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NREGS    = DEF_NREGS,
    parameter int AW       = DEF_AW,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_valid
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    if (clog2(NREGS) > AW) begin : g_bad_aw
        $error("regfile_param: AW too narrow for NREGS");
    end

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic                        wr_ok;

    // A write lands only if in range, not aimed at the zero register, and not
    // squashed by reset; the same qualifier gates the bypass path.
    assign wr_ok = we && !reset && ({1'b0, waddr} < NREGS_W)
                   && !(ZERO_REG != 0 && waddr == AW'(ZERO_IDX));

    // Register array update; reset wins over a same-cycle write.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr_ok && waddr == AW'(r)) regs[r] <= wdata;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] mux_data;
        logic [WIDTH-1:0] raw;

        assign addr = rd_addr[i*AW +: AW];

        regfile_read_mux #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_mux (
            .regs (regs),
            .addr (addr),
            .data (mux_data)
        );

        // Raw read value: array, overridden by bypass, overridden by zero register.
        always_comb begin
            raw = mux_data;
            if (BYPASS != 0 && wr_ok && waddr == addr) raw = wdata;
            if (ZERO_REG != 0 && addr == AW'(ZERO_IDX)) raw = '0;
        end

        if (READ_LAT != 0) begin : g_reg
            logic [WIDTH-1:0] q;
            logic             v;

            // Capture on request; data holds when idle, valid follows rd_en.
            always_ff @(posedge clock) begin
                if (reset) begin
                    q <= '0;
                    v <= 1'b0;
                end else begin
                    v <= rd_en[i];
                    if (rd_en[i]) q <= raw;
                end
            end

            assign rd_data[i*WIDTH +: WIDTH] = q;
            assign rd_valid[i]               = v;
        end else begin : g_comb
            logic unused_en;
            assign unused_en                 = rd_en[i];
            assign rd_data[i*WIDTH +: WIDTH] = raw;
            assign rd_valid[i]               = 1'b1;
        end
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised general-purpose register file that generalises the fixed 32x32 read-select path into NREGS registers of WIDTH bits. It provides NRD independent read ports and one write port. Options cover a hardwired zero register, write-to-read bypass, and an optional registered read stage with a valid flag. It sits in the decode/operand-fetch stage of the processor pipeline and replaces the hand-built register file plus its 32:1 read muxes.

Parameters:
WIDTH, 32, data bits per register
NREGS, 32, number of architectural registers (2..64, need not be a power of 2)
AW, 5, address width; must satisfy 2**AW >= NREGS
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read data
READ_LAT, 0, 0 = combinational read; 1 = read data registered one cycle after rd_en

Ports:
clock  in  1  rising-edge clock for all state
reset  in  1  synchronous, active-high; clears all registers and read outputs
we  in  1  write enable
waddr  in  AW  write address
wdata  in  WIDTH  write data
rd_en  in  NRD  per-port read request (used only when READ_LAT=1; ignored otherwise)
rd_addr  in  NRD*AW  packed read addresses; port i = [i*AW +: AW]
rd_data  out  NRD*WIDTH  packed read data; port i = [i*WIDTH +: WIDTH]
rd_valid  out  NRD  per-port data valid (READ_LAT=1); tied to all-ones when READ_LAT=0

Behaviour:
- Reset, synchronous on the clock edge with reset=1:
  - all NREGS registers become 0;
  - registered rd_data becomes 0 and rd_valid becomes 0.
  - Reset has priority over a write in the same cycle, so that write is dropped.
- Write: on the rising edge with we=1, reset=0 and waddr<NREGS, reg[waddr] <= wdata.
  - Writes with waddr>=NREGS are ignored.
  - Writes to waddr=0 are ignored when ZERO_REG=1.
- Raw read value for port i, in priority order:
  - 0 if rd_addr_i >= NREGS, or if ZERO_REG=1 and rd_addr_i=0;
  - else wdata if BYPASS=1, we=1 and waddr==rd_addr_i;
  - else reg[rd_addr_i].
- Bypass:
  - applies only to a legal, non-zero write in the same cycle;
  - never forwards to address 0 when ZERO_REG=1;
  - when BYPASS=0, a same-cycle read returns the old value.
- READ_LAT=0: rd_data is the raw value combinationally, with zero latency.
- READ_LAT=1:
  - on each edge, port i with rd_en[i]=1 captures its raw value (bypass evaluated in the capture cycle) and sets rd_valid[i]=1;
  - with rd_en[i]=0, rd_valid[i] <= 0 and rd_data_i holds its previous value;
  - latency is exactly 1 cycle.
- Read ports are fully independent. Multiple ports may use the same address in the same cycle, and each returns the identical value.
- There are no stalls and no back-pressure; each read issues at one per cycle per port.

Decomposition:
- Shared include/package holds:
  - the zero-register index constant (0);
  - the default WIDTH/NREGS/AW values;
  - the clog2 helper used to check AW against NREGS.
- One natural sub-module, regfile_read_mux, instantiated NRD times:
  - a parametrised NREGS:1, WIDTH-bit selector that applies the out-of-range-returns-0 rule;
  - it supersedes the fixed 32-input mux.
- Bypass, zero-register logic and the optional output register stay in regfile_param.

Test Plan:
- Reset/zero: assert reset 2 cycles, then read all 32 addresses on both ports -> every rd_data=0x00000000. With READ_LAT=1, rd_valid=0 during reset.
- Write/read-back: write reg[i]=0xA5A50000+i for i=1..31, then read each on port0 and port31-i on port1 -> exact values. reg0 reads 0 even after a write of 0xFFFFFFFF to address 0.
- Bypass: reg5=0x11111111; in one cycle we=1, waddr=5, wdata=0x22222222, rd_addr0=5 -> rd_data0=0x22222222 that cycle (BYPASS=1) or 0x11111111 (BYPASS=0). Next cycle both configs read 0x22222222.
- Registered read: READ_LAT=1; rd_en=2'b01, rd_addr0=7 with reg7=0xDEADBEEF -> next cycle rd_data0=0xDEADBEEF, rd_valid=2'b01. Drop rd_en -> rd_valid=0 and data holds.
- Reset vs write: reset=1 and we=1, waddr=3, wdata=0x12345678 in the same cycle -> reg3 reads 0 afterwards.
- Non-power-of-2: NREGS=24, AW=5; write 0xCAFE0000 to addr 28, read addr 28 -> 0. Write/read addr 23 -> value returned.
